// File: rtl/cpu_pkg.sv
// Shared types for the accumulator CPU sequencer: opcodes, FSM states and
// timeout counter width.
package cpu_pkg;

  localparam int unsigned OPCODE_W  = 3;
  localparam int unsigned TIMEOUT_W = 8;

  typedef enum logic [OPCODE_W-1:0] {
    LDA = 3'b000,
    STA = 3'b001,
    ADD = 3'b010,
    SUB = 3'b011,
    XOR = 3'b100,
    LDI = 3'b101,
    BZ  = 3'b110,
    HLT = 3'b111
  } opcode_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    MEM,
    HALT
  } state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous input; with EDGE set, the output
// is a one-cycle pulse on each synchronised rising edge instead of the level.
module sync_edge #(
  parameter bit EDGE = 1'b0
) (
  input  logic clock,
  input  logic n_reset,
  input  logic d,
  output logic q
);

  logic s1, s2, s3;

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign q = EDGE ? (s2 & ~s3) : s2;

endmodule

// File: rtl/seq_ctrl.sv
// Multi-cycle sequencer: steps each instruction through FETCH/EXEC/MEM,
// handles the dmem req/ack handshake with timeout, and run/single-step control.
module seq_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned OP_W    = 3,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic            clock,
  input  logic            n_reset,
  input  logic [OP_W-1:0] op,
  input  logic            z_flag,
  input  logic            run_sw,
  input  logic            step_btn,
  input  logic            dmem_ack,
  output logic            load_IR,
  output logic            INC_PC,
  output logic            load_PC,
  output logic            load_REG,
  output logic            ALU_add,
  output logic            ALU_sub,
  output logic            ALU_xor,
  output logic            IMM,
  output logic            WE,
  output logic            dmem_req,
  output logic            halted,
  output logic            err
);

  localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT - 1);

  state_t                 state, state_n;
  opcode_t                opc;
  logic                   run_lvl, step_pulse;
  logic                   end_instr, tmo_hit;
  logic [TIMEOUT_W-1:0]   tmo_cnt;

  assign opc = opcode_t'(op);

  sync_edge #(.EDGE(1'b0)) u_run_sync (
    .clock   (clock),
    .n_reset (n_reset),
    .d       (run_sw),
    .q       (run_lvl)
  );

  sync_edge #(.EDGE(1'b1)) u_step_sync (
    .clock   (clock),
    .n_reset (n_reset),
    .d       (step_btn),
    .q       (step_pulse)
  );

  // Last unacknowledged MEM cycle allowed before giving up on the access.
  assign tmo_hit = (state == MEM) && !dmem_ack && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state   <= IDLE;
      tmo_cnt <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_n;
      if (state != MEM)
        tmo_cnt <= '0;
      else if (!dmem_ack)
        tmo_cnt <= tmo_cnt + 1'b1;
      if (tmo_hit)
        err <= 1'b1;
    end
  end

  always_comb begin
    state_n   = state;
    end_instr = 1'b0;
    load_IR   = 1'b0;
    INC_PC    = 1'b0;
    load_PC   = 1'b0;
    load_REG  = 1'b0;
    ALU_add   = 1'b0;
    ALU_sub   = 1'b0;
    ALU_xor   = 1'b0;
    IMM       = 1'b0;
    WE        = 1'b0;
    dmem_req  = 1'b0;
    halted    = 1'b0;

    case (state)
      IDLE: begin
        if (run_lvl || step_pulse)
          state_n = FETCH;
      end
      FETCH: begin
        load_IR = 1'b1;
        INC_PC  = 1'b1;
        state_n = EXEC;
      end
      EXEC: begin
        case (opc)
          LDI: begin
            ALU_add   = 1'b1;
            IMM       = 1'b1;
            load_REG  = 1'b1;
            end_instr = 1'b1;
          end
          LDA, STA, ADD, SUB, XOR: begin
            dmem_req = 1'b1;
            state_n  = MEM;
          end
          BZ: begin
            load_PC   = z_flag;
            end_instr = 1'b1;
          end
          HLT:     state_n   = HALT;
          default: end_instr = 1'b1;
        endcase
      end
      MEM: begin
        dmem_req = 1'b1;
        WE       = (opc == STA);
        if (dmem_ack) begin
          case (opc)
            LDA, ADD: ALU_add = 1'b1;
            SUB:      ALU_sub = 1'b1;
            XOR:      ALU_xor = 1'b1;
            default:  ;
          endcase
          load_REG  = (opc != STA);
          end_instr = 1'b1;
        end else if (tmo_hit) begin
          state_n = HALT;
        end
      end
      HALT:    halted  = 1'b1;
      default: state_n = IDLE;
    endcase

    if (end_instr)
      state_n = run_lvl ? FETCH : IDLE;
  end

endmodule

// File: tb/tb_seq_ctrl.sv
// Directed-vector bench for seq_ctrl: each cycle's full control word is
// compared against a hand-built expectation table.
module tb_seq_ctrl;
  import cpu_pkg::*;

  logic       clock = 1'b0;
  logic       n_reset;
  logic [2:0] op;
  logic       z_flag, run_sw, step_btn, dmem_ack;
  logic       load_IR, INC_PC, load_PC, load_REG;
  logic       ALU_add, ALU_sub, ALU_xor, IMM, WE, dmem_req, halted, err;

  localparam logic [11:0] M_IR  = 12'h800;
  localparam logic [11:0] M_INC = 12'h400;
  localparam logic [11:0] M_PC  = 12'h200;
  localparam logic [11:0] M_REG = 12'h100;
  localparam logic [11:0] M_ADD = 12'h080;
  localparam logic [11:0] M_SUB = 12'h040;
  localparam logic [11:0] M_XOR = 12'h020;
  localparam logic [11:0] M_IMM = 12'h010;
  localparam logic [11:0] M_WE  = 12'h008;
  localparam logic [11:0] M_REQ = 12'h004;
  localparam logic [11:0] M_HLT = 12'h002;
  localparam logic [11:0] M_ERR = 12'h001;
  localparam logic [11:0] E_FETCH = M_IR | M_INC;

  logic [11:0] ctl;
  assign ctl = {load_IR, INC_PC, load_PC, load_REG, ALU_add, ALU_sub, ALU_xor,
                IMM, WE, dmem_req, halted, err};

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  logic [11:0] expq[$];

  seq_ctrl #(.OP_W(3), .TIMEOUT(15)) dut (
    .clock    (clock),
    .n_reset  (n_reset),
    .op       (op),
    .z_flag   (z_flag),
    .run_sw   (run_sw),
    .step_btn (step_btn),
    .dmem_ack (dmem_ack),
    .load_IR  (load_IR),
    .INC_PC   (INC_PC),
    .load_PC  (load_PC),
    .load_REG (load_REG),
    .ALU_add  (ALU_add),
    .ALU_sub  (ALU_sub),
    .ALU_xor  (ALU_xor),
    .IMM      (IMM),
    .WE       (WE),
    .dmem_req (dmem_req),
    .halted   (halted),
    .err      (err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  task automatic cv(input string tag, input logic [11:0] e);
    #1;
    chk(tag, 32'(ctl), 32'(e));
    chk({tag, "_inv"},
        32'({($countones({ALU_add, ALU_sub, ALU_xor}) > 1), INC_PC & load_PC}), 32'd0);
  endtask

  task automatic fill(input int n);
    expq.delete();
    repeat (n) expq.push_back(12'h000);
  endtask

  task automatic run_seq(input string tag, input opcode_t o, input logic z,
                         input logic r, input logic s, input logic [31:0] ack_at);
    op       = o;
    z_flag   = z;
    run_sw   = r;
    step_btn = s;
    for (int k = 1; k <= expq.size(); k++) begin
      nxt();
      dmem_ack = ack_at[k];
      cv($sformatf("%s_c%0d", tag, k), expq[k-1]);
    end
    dmem_ack = 1'b0;
  endtask

  task automatic gap(input int n);
    run_sw   = 1'b0;
    step_btn = 1'b0;
    repeat (n) nxt();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1);
  end

  initial begin
    opcode_t     mops[3];
    logic [11:0] malu[3];
    mops = '{LDA, SUB, XOR};
    malu = '{M_ADD, M_SUB, M_XOR};

    n_reset = 1'b0; op = 3'b000; z_flag = 1'b0;
    run_sw = 1'b0; step_btn = 1'b0; dmem_ack = 1'b0;
    repeat (2) nxt();
    cv("reset", 12'h000);
    n_reset = 1'b1;
    nxt();

    // 1: LDI in run mode, two-cycle instruction back to back
    fill(5);
    expq[2] = E_FETCH;
    expq[3] = M_ADD | M_IMM | M_REG;
    expq[4] = E_FETCH;
    run_seq("t1_ldi", LDI, 1'b0, 1'b1, 1'b0, 32'h0);
    gap(6);
    cv("t1_stop", 12'h000);

    // 2: ADD single-stepped with button held, one wait state, stray ack in IDLE
    fill(22);
    expq[2] = E_FETCH;
    expq[3] = M_REQ;
    expq[4] = M_REQ;
    expq[5] = M_REQ | M_ADD | M_REG;
    run_seq("t2_add", ADD, 1'b0, 1'b0, 1'b1, (32'd1 << 6) | (32'd1 << 9));
    gap(4);

    // 3: STA zero-wait
    fill(7);
    expq[2] = E_FETCH;
    expq[3] = M_REQ;
    expq[4] = M_REQ | M_WE;
    run_seq("t3_sta", STA, 1'b0, 1'b0, 1'b1, 32'd1 << 5);
    gap(4);

    // 3b: remaining ALU memory ops, zero-wait
    for (int i = 0; i < 3; i++) begin
      fill(6);
      expq[2] = E_FETCH;
      expq[3] = M_REQ;
      expq[4] = M_REQ | M_REG | malu[i];
      run_seq($sformatf("t3b_op%0d", i), mops[i], 1'b0, 1'b0, 1'b1, 32'd1 << 5);
      gap(4);
    end

    // 4: BZ taken then not taken
    fill(5);
    expq[2] = E_FETCH;
    expq[3] = M_PC;
    run_seq("t4_bz1", BZ, 1'b1, 1'b0, 1'b1, 32'h0);
    gap(4);
    fill(5);
    expq[2] = E_FETCH;
    run_seq("t4_bz0", BZ, 1'b0, 1'b0, 1'b1, 32'h0);
    gap(4);

    // 5: LDA never acknowledged -> timeout after 15 MEM cycles
    fill(22);
    expq[2] = E_FETCH;
    for (int k = 3; k < 19; k++) expq[k] = M_REQ;
    for (int k = 19; k < 22; k++) expq[k] = M_HLT | M_ERR;
    run_seq("t5_tmo", LDA, 1'b0, 1'b0, 1'b1, 32'h0);
    run_sw = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step_btn = ~step_btn;
      nxt();
      cv($sformatf("t5_ign%0d", k), M_HLT | M_ERR);
    end
    n_reset = 1'b0;
    cv("t5_rst", 12'h000);
    run_sw = 1'b0; step_btn = 1'b0;
    nxt();
    n_reset = 1'b1;
    gap(3);

    // 6: HLT in run mode, then reset in the middle of an STA access
    fill(7);
    expq[2] = E_FETCH;
    for (int k = 4; k < 7; k++) expq[k] = M_HLT;
    run_seq("t6_hlt", HLT, 1'b0, 1'b1, 1'b0, 32'h0);
    n_reset = 1'b0;
    cv("t6_rst_halt", 12'h000);
    run_sw = 1'b0;
    nxt();
    n_reset = 1'b1;
    gap(3);
    fill(6);
    expq[2] = E_FETCH;
    expq[3] = M_REQ;
    expq[4] = M_REQ | M_WE;
    expq[5] = M_REQ | M_WE;
    run_seq("t6_sta", STA, 1'b0, 1'b0, 1'b1, 32'h0);
    n_reset = 1'b0;
    cv("t6_rst_mid_mem", 12'h000);
    step_btn = 1'b0;
    nxt();
    n_reset = 1'b1;
    gap(3);
    cv("t6_idle", 12'h000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
